// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the matrix-multiply core: instruction layout, opcodes and
// the sequencer FSM encoding.
package instr_fetch_seq_pkg;
    localparam int PC_W    = 12;
    localparam int OPC_W   = 5;
    localparam int INSTR_W = OPC_W + PC_W;

    localparam logic [OPC_W-1:0] OP_LDAC   = 5'd3;
    localparam logic [OPC_W-1:0] OP_LDIAC  = 5'd5;
    localparam logic [OPC_W-1:0] OP_STAC   = 5'd8;
    localparam logic [OPC_W-1:0] OP_MVAC   = 5'd9;
    localparam logic [OPC_W-1:0] OP_ADD    = 5'd19;
    localparam logic [OPC_W-1:0] OP_MULT   = 5'd20;
    localparam logic [OPC_W-1:0] OP_LSHIFT = 5'd21;
    localparam logic [OPC_W-1:0] OP_SUB    = 5'd22;
    localparam logic [OPC_W-1:0] OP_INAC   = 5'd23;
    localparam logic [OPC_W-1:0] OP_JPNZ   = 5'd24;
    localparam logic [OPC_W-1:0] OP_JMPZ   = 5'd26;
    localparam logic [OPC_W-1:0] OP_NOP    = 5'd28;
    localparam logic [OPC_W-1:0] OP_ENDOP  = 5'd31;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [PC_W-1:0]  opd;
    } instr_t;

    // Ops the sequencer resolves itself; everything else goes to the datapath.
    function automatic logic is_ctrl(input logic [OPC_W-1:0] op);
        return (op == OP_JPNZ) || (op == OP_JMPZ) || (op == OP_NOP) || (op == OP_ENDOP);
    endfunction
endpackage

// File: rtl/instr_fetch_seq_if.sv
// Instruction-memory and datapath handshake bundle seen by the program sequencer.
interface instr_fetch_seq_if;
    import instr_fetch_seq_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               z_flag;
    logic               instr_valid;
    logic               instr_ready;
    logic [OPC_W-1:0]   opcode;
    logic [PC_W-1:0]    operand;

    modport master (
        output imem_addr, instr_valid, opcode, operand,
        input  imem_data, z_flag, instr_ready
    );

    modport slave (
        input  imem_addr, instr_valid, opcode, operand,
        output imem_data, z_flag, instr_ready
    );
endinterface

// File: rtl/instr_fetch_seq_pc_unit.sv
// Program counter: clear beats load beats increment; increment wraps modulo 2^PC_W.
module pc_unit
    import instr_fetch_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            ld,
    input  logic            inc,
    input  logic [PC_W-1:0] ld_val,
    output logic [PC_W-1:0] pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      pc <= '0;
        else if (clr) pc <= '0;
        else if (ld)  pc <= ld_val;
        else if (inc) pc <= pc + 1'b1;
    end
endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: FETCH/LATCH/EXEC loop over a 1-cycle-latency instruction memory,
// resolving control ops locally and forwarding the rest over valid/ready.
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_fetch_seq_if.master   bus,
    output logic                busy,
    output logic                halted
);
    logic [2:0]      state, state_nx;
    instr_t          ir;
    logic [PC_W-1:0] pc;
    logic            pc_clr, pc_ld, pc_inc;
    logic            ctrl_op, accept;

    pc_unit u_pc (
        .clk    (clk),
        .rst    (rst),
        .clr    (pc_clr),
        .ld     (pc_ld),
        .inc    (pc_inc),
        .ld_val (ir.opd),
        .pc     (pc)
    );

    // Outputs decode straight from state so an async reset clears them immediately.
    assign ctrl_op         = is_ctrl(ir.opc);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state == S_EXEC) && !ctrl_op;
    assign bus.opcode      = ir.opc;
    assign bus.operand     = ir.opd;
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign busy            = (state == S_FETCH) || (state == S_LATCH) || (state == S_EXEC);
    assign halted          = (state == S_HALT);

    always_comb begin
        state_nx = state;
        pc_clr   = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_clr   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: state_nx = S_LATCH;
            S_LATCH: state_nx = S_EXEC;
            S_EXEC: begin
                if (ir.opc == OP_ENDOP) begin
                    state_nx = S_HALT;
                end else if (ir.opc == OP_NOP) begin
                    pc_inc   = 1'b1;
                    state_nx = S_FETCH;
                end else if (ir.opc == OP_JPNZ) begin
                    pc_ld    = !bus.z_flag;
                    pc_inc   = bus.z_flag;
                    state_nx = S_FETCH;
                end else if (ir.opc == OP_JMPZ) begin
                    pc_ld    = bus.z_flag;
                    pc_inc   = !bus.z_flag;
                    state_nx = S_FETCH;
                end else if (accept) begin
                    pc_inc   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  ir <= '0;
        else if (state == S_LATCH) ir <= bus.imem_data;
    end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: behavioural imem, scoreboard of forwarded ops.
module tb_instr_fetch_seq;
    import instr_fetch_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, halted;

    instr_fetch_seq_if bus();

    instr_fetch_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    typedef struct {
        logic [OPC_W-1:0] opc;
        logic [PC_W-1:0]  opd;
        logic [PC_W-1:0]  pc;
    } sb_t;
    sb_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_vld = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accepted instructions are checked against the scoreboard away from the edge.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid) n_vld++;
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            n_acc++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("acc_opcode", 32'(bus.opcode), 32'(e.opc));
                chk("acc_operand", 32'(bus.operand), 32'(e.opd));
                chk("acc_pc", 32'(bus.imem_addr), 32'(e.pc));
            end
        end
    end

    function automatic logic [INSTR_W-1:0] mk(input logic [OPC_W-1:0] op, input int opd);
        return {op, PC_W'(opd)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = mk(OP_ENDOP, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!halted && n < 60) begin
            step(1);
            n++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic run_jump(input string tag, input logic z, input logic [OPC_W-1:0] op0,
                            input logic [OPC_W-1:0] op46, input int exp_pc);
        int v0;
        clear_mem();
        mem[0]  = mk(op0, 46);
        mem[46] = mk(op46, 40);
        bus.z_flag = z;
        v0 = n_vld;
        pulse_start();
        wait_halt({tag, "_halt"});
        chk({tag, "_pc"}, 32'(bus.imem_addr), 32'(exp_pc));
        chk({tag, "_novalid"}, 32'(n_vld - v0), 32'd0);
    endtask

    initial begin
        int a0, n;
        bus.instr_ready = 1'b0;
        bus.z_flag      = 1'b0;
        clear_mem();
        step(2);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_opcode", 32'(bus.opcode), 32'd0);
        rst = 1'b0;
        step(2);
        chk("idle_busy", 32'(busy), 32'd0);

        // ADD, NOP, ENDOP with ready held high
        mem[0] = mk(OP_ADD, 7);
        mem[1] = mk(OP_NOP, 0);
        mem[2] = mk(OP_ENDOP, 0);
        bus.instr_ready = 1'b1;
        sb.push_back('{OP_ADD, 12'd7, 12'd0});
        a0 = n_acc;
        pulse_start();
        chk("p1_busy", 32'(busy), 32'd1);
        wait_halt("p1_halt");
        chk("p1_accepts", 32'(n_acc - a0), 32'd1);
        chk("p1_pc", 32'(bus.imem_addr), 32'd2);
        step(3);
        chk("p1_pc_hold", 32'(bus.imem_addr), 32'd2);
        chk("p1_still_halted", 32'(halted), 32'd1);

        // restart from HALT; ADD at pc 5 stalled by ready low
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = mk(OP_NOP, 0);
        mem[5] = mk(OP_ADD, 12'h55);
        bus.instr_ready = 1'b0;
        sb.push_back('{OP_ADD, 12'h55, 12'd5});
        a0 = n_acc;
        pulse_start();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_addr", 32'(bus.imem_addr), 32'd0);
        chk("restart_halted", 32'(halted), 32'd0);
        n = 0;
        while (!bus.instr_valid && n < 40) begin
            step(1);
            n++;
        end
        chk("stall_valid_seen", 32'(bus.instr_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_opcode", 32'(bus.opcode), 32'(OP_ADD));
            chk("stall_operand", 32'(bus.operand), 32'h55);
            chk("stall_pc", 32'(bus.imem_addr), 32'd5);
        end
        pulse_start();
        chk("busy_start_pc", 32'(bus.imem_addr), 32'd5);
        chk("busy_start_valid", 32'(bus.instr_valid), 32'd1);
        bus.instr_ready = 1'b1;
        step(1);
        bus.instr_ready = 1'b0;
        chk("stall_accepts", 32'(n_acc - a0), 32'd1);
        wait_halt("stall_halt");
        chk("stall_end_pc", 32'(bus.imem_addr), 32'd6);

        // conditional jumps
        run_jump("jpnz_taken", 1'b0, OP_JPNZ, OP_JPNZ, 40);
        run_jump("jpnz_fall", 1'b1, OP_JMPZ, OP_JPNZ, 47);
        run_jump("jmpz_taken", 1'b1, OP_JMPZ, OP_JMPZ, 40);
        run_jump("jmpz_fall", 1'b0, OP_JPNZ, OP_JMPZ, 47);

        // nop at 4095 wraps to 0; second pass of jmpz falls through to endop at 1
        clear_mem();
        mem[0]    = mk(OP_JMPZ, 4095);
        mem[4095] = mk(OP_NOP, 0);
        bus.z_flag = 1'b1;
        pulse_start();
        n = 0;
        while (bus.imem_addr != 12'd4095 && n < 30) begin
            step(1);
            n++;
        end
        chk("wrap_reach", 32'(bus.imem_addr), 32'd4095);
        bus.z_flag = 1'b0;
        n = 0;
        while (bus.imem_addr == 12'd4095 && n < 30) begin
            step(1);
            n++;
        end
        chk("wrap_addr", 32'(bus.imem_addr), 32'd0);
        wait_halt("wrap_halt");
        chk("wrap_end_pc", 32'(bus.imem_addr), 32'd1);

        // reset in EXEC with valid high
        clear_mem();
        mem[0] = mk(OP_NOP, 0);
        mem[1] = mk(OP_SUB, 3);
        pulse_start();
        n = 0;
        while (!bus.instr_valid && n < 30) begin
            step(1);
            n++;
        end
        chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_halted", 32'(halted), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
